shift_add_mult_ctrl: RTL

//  Sequencer for an external right_shift_register (load/shift, DATA_SIZE bits) that performs

---
 rtl/alu_mult_pkg.sv | 13 +
 rtl/mult_step_adder.sv | 14 +
 rtl/right_shift_register.sv | 23 ++
 rtl/shift_add_mult_ctrl.sv | 102 ++++++++++
 4 files changed

// File: rtl/alu_mult_pkg.sv
// rtl/alu_mult_pkg.sv - shared FSM and shift-register control encodings for the multiply path
package alu_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mult_state_t;

  localparam logic SR_LOAD  = 1'b0;
  localparam logic SR_SHIFT = 1'b1;

endpackage

// File: rtl/mult_step_adder.sv
// rtl/mult_step_adder.sv - one add step: acc plus multiplicand gated by the current multiplier bit
module mult_step_adder #(
  parameter int DATA_SIZE = 8
) (
  input  logic [DATA_SIZE-1:0] acc,
  input  logic [DATA_SIZE-1:0] mcand,
  input  logic                 sel,
  output logic [DATA_SIZE:0]   sum
);

  // One bit wider than the operands so the carry is kept for the shift.
  assign sum = {1'b0, acc} + (sel ? {1'b0, mcand} : '0);

endmodule

// File: rtl/right_shift_register.sv
// rtl/right_shift_register.sv - loadable right shift register driven by the multiply sequencer
module right_shift_register #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 shift_load,
  input  logic [DATA_SIZE-1:0] d,
  input  logic                 d_shift,
  output logic [DATA_SIZE-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      if (shift_load) q <= {d_shift, q[DATA_SIZE-1:1]};
      else            q <= d;
    end
  end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// rtl/shift_add_mult_ctrl.sv - shift-and-add multiply sequencer for an external shift register
// Optional MULT_ZERO_SKIP_EN: zero operands bypass CALC and finish one cycle after accept.
module shift_add_mult_ctrl
  import alu_mult_pkg::*;
#(
  parameter int DATA_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_SIZE-1:0]   in_a,
  input  logic [DATA_SIZE-1:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*DATA_SIZE-1:0] out_p,
  output logic                   busy,
  output logic                   sr_en,
  output logic                   sr_shift_load,
  output logic [DATA_SIZE-1:0]   sr_d,
  output logic                   sr_d_shift,
  input  logic [DATA_SIZE-1:0]   sr_q
);

  localparam int CNT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_SIZE - 1);

  mult_state_t          state;
  logic [DATA_SIZE-1:0] acc;
  logic [DATA_SIZE-1:0] mcand;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_SIZE:0]   sum;
  logic                 accept;
  logic                 zero_skip;

  mult_step_adder #(.DATA_SIZE(DATA_SIZE)) u_step (
    .acc   (acc),
    .mcand (mcand),
    .sel   (sr_q[0]),
    .sum   (sum)
  );

  assign accept = (state == ST_IDLE) && in_valid;

`ifdef MULT_ZERO_SKIP_EN
  assign zero_skip = (in_a == '0) || (in_b == '0);
`else
  assign zero_skip = 1'b0;
`endif

  always_comb begin
    in_ready      = (state == ST_IDLE);
    out_valid     = (state == ST_DONE);
    busy          = (state == ST_CALC) || (state == ST_DONE);
    sr_en         = 1'b0;
    sr_shift_load = SR_LOAD;
    sr_d          = '0;
    sr_d_shift    = 1'b0;
    out_p         = '0;
    if (accept) begin
      sr_en = 1'b1;
      sr_d  = zero_skip ? '0 : in_b;
    end
    if (state == ST_CALC) begin
      sr_en         = 1'b1;
      sr_shift_load = SR_SHIFT;
      sr_d_shift    = sum[0];
    end
    if (state == ST_DONE) out_p = {acc, sr_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mcand <= in_a;
            acc   <= '0;
            cnt   <= '0;
            state <= zero_skip ? ST_DONE : ST_CALC;
          end
        end
        ST_CALC: begin
          // Low sum bit leaves through the shift register; the rest becomes the new high half.
          acc <= sum[DATA_SIZE:1];
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
